ws2812_frame_ctrl: RTL and testbench



---
 rtl/ws2812_pkg.sv | 28 ++
 rtl/ws2812_rx_parser.sv | 81 ++++++++
 rtl/ws2812_frame_ctrl.sv | 155 +++++++++++++++
 tb/tb_ws2812_frame_ctrl.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ws2812_pkg.sv
// Shared types and default timing for the WS2812 frame controller.
package ws2812_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_WAIT,
    S_LATCH
  } sched_state_e;

  typedef enum logic [1:0] {
    P_IDX,
    P_G,
    P_R,
    P_B
  } parse_state_e;

  // {G,R,B}, G in the top byte so bit 23 goes out first.
  typedef logic [23:0] grb_t;

  // Defaults for a 20 MHz clock: 750 us latch gap (comfortably past the
  // ~280 us reset time of newer parts), 2.5 ms inter-byte timeout.
  localparam int unsigned DEF_LATCH_CYCLES = 15000;
  localparam int unsigned DEF_RX_TIMEOUT   = 50000;
  localparam int unsigned DEF_ACK_TIMEOUT  = 1024;

endpackage

// File: rtl/ws2812_rx_parser.sv
// UART byte parser: {index, G, R, B} packets -> pixel buffer write strobe.
module ws2812_rx_parser
  import ws2812_pkg::*;
#(
  parameter int unsigned NUM_LEDS   = 3,
  parameter int unsigned RX_TIMEOUT = DEF_RX_TIMEOUT,
  localparam int unsigned AW = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
  input  logic          i_Clock,
  input  logic          i_Reset,
  input  logic          i_Rx_DV,
  input  logic [7:0]    i_Rx_Byte,
  output logic          o_Wr_En,
  output logic [AW-1:0] o_Wr_Idx,
  output grb_t          o_Wr_Data,
  output logic          o_Err
);

  localparam int unsigned TW = $clog2(RX_TIMEOUT + 1);

  parse_state_e  state_q, state_d;
  logic [7:0]    idx_q, g_q, r_q;
  logic [TW-1:0] idle_q, idle_d;
  logic          timed_out;
  logic          idx_ok;

  // Idle counter saturates at RX_TIMEOUT so it never wraps back to "active".
  assign timed_out = (idle_q == TW'(RX_TIMEOUT));
  assign idx_ok    = ({1'b0, idx_q} < 9'(NUM_LEDS));

  // Next-state: one step per byte, silent fall-back to IDX on a stalled packet.
  always_comb begin
    state_d = state_q;
    idle_d  = idle_q;
    o_Wr_En = 1'b0;
    o_Err   = 1'b0;
    if (i_Rx_DV) begin
      idle_d = '0;
      case (state_q)
        P_IDX:   state_d = P_G;
        P_G:     state_d = P_R;
        P_R:     state_d = P_B;
        default: begin
          state_d = P_IDX;
          o_Wr_En = idx_ok;
          o_Err   = !idx_ok;
        end
      endcase
    end else begin
      if (!timed_out) idle_d = idle_q + TW'(1);
      if (timed_out && state_q != P_IDX) state_d = P_IDX;
    end
  end

  // State, idle counter and captured packet bytes.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q <= P_IDX;
      idle_q  <= '0;
      idx_q   <= '0;
      g_q     <= '0;
      r_q     <= '0;
    end else begin
      state_q <= state_d;
      idle_q  <= idle_d;
      if (i_Rx_DV) begin
        case (state_q)
          P_IDX:   idx_q <= i_Rx_Byte;
          P_G:     g_q   <= i_Rx_Byte;
          P_R:     r_q   <= i_Rx_Byte;
          default: ;
        endcase
      end
    end
  end

  // B byte is taken straight from the bus so the write lands on its own edge.
  assign o_Wr_Idx  = idx_q[AW-1:0];
  assign o_Wr_Data = {g_q, r_q, i_Rx_Byte};

endmodule

// File: rtl/ws2812_frame_ctrl.sv
// Frame scheduler: pixel buffer, per-pixel start/ready handshake, latch gap.
module ws2812_frame_ctrl
  import ws2812_pkg::*;
#(
  parameter int unsigned NUM_LEDS     = 3,
  parameter int unsigned LATCH_CYCLES = DEF_LATCH_CYCLES,
  parameter int unsigned RX_TIMEOUT   = DEF_RX_TIMEOUT,
  parameter int unsigned ACK_TIMEOUT  = DEF_ACK_TIMEOUT
) (
  input  logic        i_Clock,
  input  logic        i_Reset,
  input  logic        i_Rx_DV,
  input  logic [7:0]  i_Rx_Byte,
  input  logic        i_Refresh,
  input  logic        i_Ser_Ready,
  output logic        o_Ser_Start,
  output logic [23:0] o_Ser_Pixel,
  output logic        o_Busy,
  output logic        o_Frame_Done,
  output logic        o_Err
);

  localparam int unsigned PW   = $clog2(NUM_LEDS) + 1;
  localparam int unsigned AW   = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
  localparam int unsigned CMAX = (LATCH_CYCLES > ACK_TIMEOUT) ? LATCH_CYCLES : ACK_TIMEOUT;
  localparam int unsigned CW   = $clog2(CMAX + 1);

  logic          wr_en;
  logic [AW-1:0] wr_idx;
  grb_t          wr_data;
  logic          parse_err;

  grb_t          buf_q [NUM_LEDS];

  sched_state_e  state_q, state_d;
  logic [PW-1:0] pix_idx_q, pix_idx_d;
  grb_t          pixel_q, pixel_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          dirty_q, dirty_d;
  logic          refresh_q, refresh_d;
  logic          done_q, done_d;
  logic          err_q;
  logic          ack_to;

  ws2812_rx_parser #(
    .NUM_LEDS   (NUM_LEDS),
    .RX_TIMEOUT (RX_TIMEOUT)
  ) u_parser (
    .i_Clock   (i_Clock),
    .i_Reset   (i_Reset),
    .i_Rx_DV   (i_Rx_DV),
    .i_Rx_Byte (i_Rx_Byte),
    .o_Wr_En   (wr_en),
    .o_Wr_Idx  (wr_idx),
    .o_Wr_Data (wr_data),
    .o_Err     (parse_err)
  );

  // Pixel buffer: written whenever a packet completes, regardless of scheduler state.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      for (int i = 0; i < NUM_LEDS; i++) buf_q[i] <= '0;
    end else if (wr_en) begin
      buf_q[wr_idx] <= wr_data;
    end
  end

  // Scheduler next-state; shared counter times both the ack wait and the latch gap.
  always_comb begin
    state_d   = state_q;
    pix_idx_d = pix_idx_q;
    pixel_d   = pixel_q;
    cnt_d     = '0;
    dirty_d   = dirty_q;
    refresh_d = refresh_q;
    done_d    = 1'b0;
    ack_to    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if ((dirty_q || refresh_q) && i_Ser_Ready) begin
          state_d   = S_LOAD;
          pix_idx_d = '0;
          dirty_d   = 1'b0;
          refresh_d = 1'b0;
        end
      end
      S_LOAD: begin
        pixel_d = buf_q[pix_idx_q[AW-1:0]];
        state_d = S_START;
      end
      S_START: begin
        if (!i_Ser_Ready) begin
          state_d = S_WAIT;
        end else if (cnt_q == CW'(ACK_TIMEOUT - 1)) begin
          ack_to  = 1'b1;
          state_d = S_LATCH;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_WAIT: begin
        if (i_Ser_Ready) begin
          if (pix_idx_q < PW'(NUM_LEDS - 1)) begin
            pix_idx_d = pix_idx_q + PW'(1);
            state_d   = S_LOAD;
          end else begin
            state_d = S_LATCH;
          end
        end
      end
      S_LATCH: begin
        if (cnt_q == CW'(LATCH_CYCLES - 1)) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    // New requests win over the clear taken when a frame begins.
    if (wr_en)     dirty_d   = 1'b1;
    if (i_Refresh) refresh_d = 1'b1;
  end

  // Scheduler registers; reset forces a full re-blank.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q   <= S_IDLE;
      pix_idx_q <= '0;
      pixel_q   <= '0;
      cnt_q     <= '0;
      dirty_q   <= 1'b1;
      refresh_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pix_idx_q <= pix_idx_d;
      pixel_q   <= pixel_d;
      cnt_q     <= cnt_d;
      dirty_q   <= dirty_d;
      refresh_q <= refresh_d;
      done_q    <= done_d;
      err_q     <= parse_err | ack_to;
    end
  end

  assign o_Ser_Start  = (state_q == S_START);
  assign o_Ser_Pixel  = pixel_q;
  assign o_Busy       = (state_q != S_IDLE);
  assign o_Frame_Done = done_q;
  assign o_Err        = err_q;

endmodule

// File: tb/tb_ws2812_frame_ctrl.sv
// Randomized self-checking bench for ws2812_frame_ctrl with a serializer model.
module tb_ws2812_frame_ctrl;

  localparam int N     = 3;
  localparam int LAT   = 40;
  localparam int RXTO  = 60;
  localparam int ACKTO = 20;
  localparam int HOLD  = 100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_dv = 1'b0;
  logic [7:0]  rx_byte = 8'h00;
  logic        refresh = 1'b0;
  logic        ser_rdy = 1'b1;
  logic        hold_off = 1'b0;
  logic        stuck = 1'b0;
  logic        ready_in;
  logic        start, busy, done, err;
  logic [23:0] pix;

  assign ready_in = ser_rdy & ~hold_off;

  always #5 clk = ~clk;

  ws2812_frame_ctrl #(
    .NUM_LEDS     (N),
    .LATCH_CYCLES (LAT),
    .RX_TIMEOUT   (RXTO),
    .ACK_TIMEOUT  (ACKTO)
  ) dut (
    .i_Clock      (clk),
    .i_Reset      (rst),
    .i_Rx_DV      (rx_dv),
    .i_Rx_Byte    (rx_byte),
    .i_Refresh    (refresh),
    .i_Ser_Ready  (ready_in),
    .o_Ser_Start  (start),
    .o_Ser_Pixel  (pix),
    .o_Busy       (busy),
    .o_Frame_Done (done),
    .o_Err        (err)
  );

  int n_chk = 0, n_err = 0;
  int cyc = 0, n_done = 0, n_errp = 0, start_hi = 0, done_cyc = 0, rise_cyc = 0;
  int exp_errp = 0;
  logic        start_prev = 1'b0;
  logic [23:0] sent [$];
  logic [23:0] mbuf [N];
  logic [23:0] zero [N];

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: capture the pixel at every start request, count pulses.
  always @(negedge clk) begin
    if (start && !start_prev) sent.push_back(pix);
    if (start) start_hi <= start_hi + 1;
    if (done) begin
      n_done   <= n_done + 1;
      done_cyc <= cyc;
    end
    if (err) n_errp <= n_errp + 1;
    start_prev <= start;
  end

  // Serializer: drops ready 3 cycles after a start, raises it HOLD cycles later.
  initial begin
    forever begin
      @(negedge clk);
      if (!stuck && start && ser_rdy) begin
        repeat (3) @(negedge clk);
        ser_rdy = 1'b0;
        repeat (HOLD) @(negedge clk);
        ser_rdy  = 1'b1;
        rise_cyc = cyc;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_dv   = 1'b1;
    rx_byte = b;
    @(negedge clk);
    rx_dv = 1'b0;
  endtask

  task automatic send_pkt(input logic [7:0] i, input logic [7:0] g, input logic [7:0] r,
                          input logic [7:0] b);
    send_byte(i);
    send_byte(g);
    send_byte(r);
    send_byte(b);
    if (int'(i) < N) mbuf[i] = {g, r, b};
    else exp_errp++;
  endtask

  task automatic pulse_refresh();
    @(negedge clk);
    refresh = 1'b1;
    @(negedge clk);
    refresh = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int base);
    int t = 0;
    while (n_done <= base && t < 20000) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    chk({tag, "_done"}, 32'(n_done > base), 32'd1);
  endtask

  task automatic check_frame(input string tag, input int b, input logic [23:0] e [N]);
    chk({tag, "_cnt"}, 32'(sent.size() - b), 32'(N));
    for (int i = 0; i < N; i++)
      chk($sformatf("%s_px%0d", tag, i),
          (b + i < sent.size()) ? 32'(sent[b + i]) : 32'hDEAD_BEEF, 32'(e[i]));
  endtask

  task automatic wait_sent(input int target);
    int t = 0;
    while (sent.size() < target && t < 5000) begin
      @(negedge clk);
      t++;
    end
    chk("wait_sent", 32'(sent.size() >= target), 32'd1);
  endtask

  initial begin
    int base, dbase, t, sh, eb, nvalid, npk, idx;
    logic [23:0] snap [N];
    logic [31:0] rnd;
    logic        do_ref;

    for (int i = 0; i < N; i++) begin
      mbuf[i] = '0;
      zero[i] = '0;
    end

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_start", 32'(start), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_pix", 32'(pix), 32'd0);

    // Blanking frame right after reset, then the latch gap
    base = sent.size();
    dbase = n_done;
    rst = 1'b0;
    wait_done("blank", dbase);
    check_frame("blank", base, zero);
    t = done_cyc - rise_cyc;
    chk("latch_gap", 32'(t >= LAT && t <= LAT + 2), 32'd1);
    chk("idle_after", 32'(busy), 32'd0);

    // Single pixel write
    base = sent.size();
    dbase = n_done;
    send_pkt(8'h01, 8'hFF, 8'h00, 8'h80);
    wait_done("wr1", dbase);
    check_frame("wr1", base, mbuf);

    // Out-of-range index: error only, no frame
    base = sent.size();
    send_pkt(8'h05, 8'h11, 8'h22, 8'h33);
    repeat (150) @(negedge clk);
    chk("badidx_err", 32'(n_errp), 32'(exp_errp));
    chk("badidx_noframe", 32'(sent.size() - base), 32'd0);
    chk("badidx_busy", 32'(busy), 32'd0);

    // Stalled partial packet is dropped silently
    send_byte(8'h00);
    send_byte(8'hAA);
    repeat (RXTO + 5) @(negedge clk);
    base = sent.size();
    dbase = n_done;
    send_pkt(8'h02, 8'h01, 8'h02, 8'h03);
    wait_done("rxto", dbase);
    check_frame("rxto", base, mbuf);
    chk("rxto_err", 32'(n_errp), 32'(exp_errp));

    // Write pixel 0 while pixel 1 is in flight: old value now, new value next frame
    base = sent.size();
    dbase = n_done;
    send_pkt(8'h01, 8'h12, 8'h34, 8'h56);
    snap = mbuf;
    wait_sent(base + 2);
    t = 0;
    while (ready_in && t < 200) begin
      @(negedge clk);
      t++;
    end
    send_pkt(8'h00, 8'hC0, 8'hFF, 8'hEE);
    wait_done("mid1", dbase);
    check_frame("mid1", base, snap);
    wait_done("mid2", dbase + 1);
    check_frame("mid2", base + N, mbuf);

    // Randomized bursts collected while the serializer is held off
    for (int it = 0; it < 8; it++) begin
      hold_off = 1'b1;
      repeat (2) @(negedge clk);
      base = sent.size();
      dbase = n_done;
      nvalid = 0;
      npk = $urandom_range(1, 3);
      for (int k = 0; k < npk; k++) begin
        idx = $urandom_range(0, 4);
        rnd = $urandom;
        send_pkt(8'(idx), rnd[23:16], rnd[15:8], rnd[7:0]);
        if (idx < N) nvalid++;
      end
      do_ref = ($urandom_range(0, 3) == 0);
      if (do_ref) pulse_refresh();
      hold_off = 1'b0;
      if (nvalid > 0 || do_ref) begin
        wait_done($sformatf("rnd%0d", it), dbase);
        check_frame($sformatf("rnd%0d", it), base, mbuf);
      end else begin
        repeat (60) @(negedge clk);
        chk($sformatf("rnd%0d_noframe", it), 32'(sent.size() - base), 32'd0);
      end
    end
    repeat (4) @(negedge clk);
    chk("rnd_err", 32'(n_errp), 32'(exp_errp));

    // Serializer never acknowledges: error, abort, latch, idle
    stuck = 1'b1;
    base = sent.size();
    dbase = n_done;
    sh = start_hi;
    eb = n_errp;
    pulse_refresh();
    wait_done("ackto", dbase);
    t = start_hi - sh;
    chk("ackto_len", 32'(t >= ACKTO - 1 && t <= ACKTO + 1), 32'd1);
    chk("ackto_starts", 32'(sent.size() - base), 32'd1);
    chk("ackto_err", 32'(n_errp - eb), 32'd1);
    chk("ackto_start_lo", 32'(start), 32'd0);
    chk("ackto_idle", 32'(busy), 32'd0);
    stuck = 1'b0;
    base = sent.size();
    dbase = n_done;
    pulse_refresh();
    wait_done("retry", dbase);
    check_frame("retry", base, mbuf);

    // Reset in the middle of a frame re-blanks the strip
    base = sent.size();
    pulse_refresh();
    wait_sent(base + 2);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_start", 32'(start), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    for (int i = 0; i < N; i++) mbuf[i] = '0;
    base = sent.size();
    dbase = n_done;
    rst = 1'b0;
    wait_done("reblank", dbase);
    check_frame("reblank", base, mbuf);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
